// File: rtl/recognition_controller_pkg.sv
// recognition_controller_pkg: shared state encoding, display code offsets and a clog2 helper
package recognition_controller_pkg;
  typedef enum logic [3:0] {
    S_RESET, S_INIT_WAIT, S_CLEAR_START, S_CLEAR_WAIT, S_IDLE,
    S_NN_START, S_NN_WAIT, S_DISPLAY, S_ERROR
  } state_t;
  localparam int BLANK_OFFSET = 0;
  localparam int ERR_OFFSET = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/recognition_controller_result_history.sv
// result_history: shift register of the last DEPTH results (slot 0 newest) with saturating count
module result_history #(
  parameter int DEPTH = 4,
  parameter int W = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 d,
  output logic [DEPTH*W-1:0]           digits,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CN = $clog2(DEPTH + 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      digits <= '0;
      count <= '0;
    end else if (push) begin
      for (int i = DEPTH - 1; i > 0; i--) digits[i*W +: W] <= digits[(i-1)*W +: W];
      digits[W-1:0] <= d;
      count <= count == CN'(DEPTH) ? count : count + 1'b1;
    end
  end
endmodule

// File: rtl/recognition_controller.sv
// recognition_controller: master FSM sequencing display init/clear, NN forward pass and result display
module recognition_controller
  import recognition_controller_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int DIGIT_W = 4,
  parameter int NN_TIMEOUT = 1048576,
  parameter int CLEAR_TIMEOUT = 1048576,
  parameter int AUTO_CLEAR = 0,
  parameter int HISTORY_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  en,
  input  logic                                  button,
  input  logic                                  graphic_driver_initialized,
  input  logic                                  painter_ready,
  output logic                                  clear_display,
  output logic                                  reset_display,
  output logic                                  enable_graphics,
  output logic                                  start_neural_network,
  output logic                                  enable_neural_network,
  output logic                                  reset_neural_network,
  input  logic                                  neural_network_done,
  input  logic [DIGIT_W-1:0]                    predicted_digit,
  output logic [DIGIT_W-1:0]                    output_digit,
  output logic                                  error,
  output logic [HISTORY_DEPTH*DIGIT_W-1:0]      history_digits,
  output logic [$clog2(HISTORY_DEPTH+1)-1:0]    history_count
);
  localparam int LIM_A = NN_TIMEOUT > CLEAR_TIMEOUT ? NN_TIMEOUT : CLEAR_TIMEOUT;
  localparam int LIM = LIM_A > AUTO_CLEAR ? LIM_A : AUTO_CLEAR;
  localparam int CW = clog2(LIM + 1) < 1 ? 1 : clog2(LIM + 1);
  localparam logic [DIGIT_W-1:0] BLANK = DIGIT_W'(NUM_CLASSES + BLANK_OFFSET);
  localparam logic [DIGIT_W-1:0] ERR = DIGIT_W'(NUM_CLASSES + ERR_OFFSET);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [DIGIT_W-1:0] result_q;
  logic button_q, btn_rise, nn_to, clr_to, auto_to, valid_done;
  assign btn_rise = button & ~button_q;
  // A zero limit disables the corresponding timer.
  assign nn_to = NN_TIMEOUT != 0 && cnt == CW'(NN_TIMEOUT - 1);
  assign clr_to = CLEAR_TIMEOUT != 0 && cnt == CW'(CLEAR_TIMEOUT - 1);
  assign auto_to = AUTO_CLEAR != 0 && cnt == CW'(AUTO_CLEAR - 1);
  assign valid_done = state == S_NN_WAIT && neural_network_done && predicted_digit < DIGIT_W'(NUM_CLASSES);
  always_comb begin
    state_n = state;
    {enable_graphics, reset_display, clear_display, enable_neural_network, reset_neural_network, start_neural_network} = 6'b000000;
    case (state)
      S_RESET: begin
        {enable_graphics, reset_display, clear_display, enable_neural_network, reset_neural_network, start_neural_network} = 6'b111010;
        state_n = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        {enable_graphics, reset_display, clear_display, enable_neural_network, reset_neural_network, start_neural_network} = 6'b100010;
        state_n = graphic_driver_initialized ? S_CLEAR_START : clr_to ? S_ERROR : S_INIT_WAIT;
      end
      S_CLEAR_START: begin
        {enable_graphics, reset_display, clear_display, enable_neural_network, reset_neural_network, start_neural_network} = 6'b101010;
        state_n = S_CLEAR_WAIT;
      end
      S_CLEAR_WAIT: begin
        {enable_graphics, reset_display, clear_display, enable_neural_network, reset_neural_network, start_neural_network} = 6'b100010;
        state_n = painter_ready ? S_IDLE : clr_to ? S_ERROR : S_CLEAR_WAIT;
      end
      S_IDLE: begin
        {enable_graphics, reset_display, clear_display, enable_neural_network, reset_neural_network, start_neural_network} = 6'b100010;
        state_n = btn_rise ? S_NN_START : S_IDLE;
      end
      S_NN_START: begin
        {enable_graphics, reset_display, clear_display, enable_neural_network, reset_neural_network, start_neural_network} = 6'b000101;
        state_n = S_NN_WAIT;
      end
      S_NN_WAIT: begin
        {enable_graphics, reset_display, clear_display, enable_neural_network, reset_neural_network, start_neural_network} = 6'b000100;
        state_n = neural_network_done ? (valid_done ? S_DISPLAY : S_ERROR) : nn_to ? S_ERROR : S_NN_WAIT;
      end
      S_DISPLAY: state_n = btn_rise || auto_to ? S_CLEAR_START : S_DISPLAY;
      S_ERROR: begin
        {enable_graphics, reset_display, clear_display, enable_neural_network, reset_neural_network, start_neural_network} = 6'b000010;
        state_n = btn_rise ? S_RESET : S_ERROR;
      end
      default: state_n = S_RESET;
    endcase
  end
  assign error = state == S_ERROR;
  assign output_digit = state == S_DISPLAY ? result_q : state == S_ERROR ? ERR : BLANK;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RESET;
      cnt <= '0;
      button_q <= 1'b0;
      result_q <= '0;
    end else if (en) begin
      state <= state_n;
      cnt <= state_n != state ? '0 : &cnt ? cnt : cnt + 1'b1;
      button_q <= button;
      if (valid_done) result_q <= predicted_digit;
    end
  end
  result_history #(.DEPTH(HISTORY_DEPTH), .W(DIGIT_W)) u_hist (
    .clk(clk),
    .reset(reset),
    .push(en & valid_done),
    .d(predicted_digit),
    .digits(history_digits),
    .count(history_count)
  );
endmodule

// File: tb/tb_recognition_controller.sv
// tb_recognition_controller: directed stimulus with a phase-level reference model checked every cycle
module tb_recognition_controller;
  logic clk = 0, reset = 1, en = 1, button = 0, gdi = 0, pr = 0, done = 0;
  logic [3:0] pd = 0;
  logic clear_display, reset_display, enable_graphics, start_nn, enable_nn, reset_nn, error;
  logic [3:0] output_digit;
  logic [15:0] history_digits;
  logic [2:0] history_count;
  int n_checks = 0, n_fail = 0;
  recognition_controller #(.NN_TIMEOUT(16), .CLEAR_TIMEOUT(32), .AUTO_CLEAR(8), .HISTORY_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .button(button),
    .graphic_driver_initialized(gdi), .painter_ready(pr),
    .clear_display(clear_display), .reset_display(reset_display), .enable_graphics(enable_graphics),
    .start_neural_network(start_nn), .enable_neural_network(enable_nn), .reset_neural_network(reset_nn),
    .neural_network_done(done), .predicted_digit(pd), .output_digit(output_digit), .error(error),
    .history_digits(history_digits), .history_count(history_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  string st = "RESET";
  int dwell = 0;
  bit bq = 0, live = 0;
  logic [3:0] res = 0;
  logic [3:0] hist[$];
  always @(posedge clk) begin
    string nxt;
    bit rise;
    if (reset) begin
      st = "RESET"; dwell = 0; bq = 0; res = 0; hist.delete(); live = 1;
    end else if (en) begin
      rise = button && !bq;
      bq = button;
      nxt = st;
      if (st == "RESET") nxt = "INIT_WAIT";
      else if (st == "INIT_WAIT") nxt = gdi ? "CLEAR_START" : dwell == 31 ? "ERROR" : st;
      else if (st == "CLEAR_START") nxt = "CLEAR_WAIT";
      else if (st == "CLEAR_WAIT") nxt = pr ? "IDLE" : dwell == 31 ? "ERROR" : st;
      else if (st == "IDLE") nxt = rise ? "NN_START" : st;
      else if (st == "NN_START") nxt = "NN_WAIT";
      else if (st == "NN_WAIT") begin
        if (done && pd < 10) begin
          nxt = "DISPLAY"; res = pd; hist.push_front(pd);
          if (hist.size() > 4) void'(hist.pop_back());
        end else nxt = done || dwell == 15 ? "ERROR" : st;
      end
      else if (st == "DISPLAY") nxt = rise || dwell == 7 ? "CLEAR_START" : st;
      else if (st == "ERROR") nxt = rise ? "RESET" : st;
      dwell = nxt == st ? dwell + 1 : 0;
      st = nxt;
    end
  end
  function automatic logic [5:0] ctl(input string s);
    if (s == "RESET") return 6'b111010;
    if (s == "CLEAR_START") return 6'b101010;
    if (s == "INIT_WAIT" || s == "CLEAR_WAIT" || s == "IDLE") return 6'b100010;
    if (s == "NN_START") return 6'b000101;
    if (s == "NN_WAIT") return 6'b000100;
    if (s == "ERROR") return 6'b000010;
    return 6'b000000;
  endfunction
  int start_cnt = 0, disp_cnt = 0, nnw_run = 0, last_nnw = 0;
  always @(negedge clk) begin
    logic [15:0] h;
    if (live) begin
      h = '0;
      foreach (hist[i]) h[i*4 +: 4] = hist[i];
      check({"ctl@", st}, {enable_graphics, reset_display, clear_display, enable_nn, reset_nn, start_nn}, ctl(st));
      check({"digit@", st}, output_digit, st == "DISPLAY" ? res : st == "ERROR" ? 4'd11 : 4'd10);
      check({"error@", st}, error, st == "ERROR");
      check("history", history_digits, h);
      check("history_count", history_count, hist.size());
      if (start_nn) start_cnt++;
      if (output_digit < 10) disp_cnt++;
      if (enable_nn && !start_nn) nnw_run++;
      else if (nnw_run != 0) begin last_nnw = nnw_run; nnw_run = 0; end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press();
    button = 1; tick(1); button = 0; tick(1);
  endtask
  task automatic run_digit(input logic [3:0] d);
    press(); tick(2);
    done = 1; pd = d; tick(1); done = 0; tick(12);
  endtask
  initial begin
    int s0, d0;
    tick(3);
    check("rst_reset_display", reset_display, 1);
    check("rst_clear_display", clear_display, 1);
    check("rst_digit", output_digit, 10);
    reset = 0; gdi = 1;
    tick(5); pr = 1; tick(2);
    check("idle_clear", clear_display, 0);
    check("idle_rst_nn", reset_nn, 1);
    check("idle_digit", output_digit, 10);
    s0 = start_cnt; d0 = disp_cnt;
    button = 1; tick(4);
    done = 1; pd = 7; tick(1); done = 0;
    check("t2_digit", output_digit, 7);
    check("t2_count", history_count, 1);
    tick(15); button = 0; tick(2);
    check("t2_one_start", start_cnt - s0, 1);
    check("t2_auto_clear_dwell", disp_cnt - d0, 8);
    check("t2_back_idle", enable_graphics, 1);
    press(); tick(2);
    en = 0; tick(3); button = 1; tick(2); button = 0; tick(5); en = 1;
    tick(5);
    check("t6_frozen_no_timeout", error, 0);
    done = 1; pd = 1; tick(1); done = 0;
    check("t6_digit", output_digit, 1);
    tick(12);
    run_digit(2); run_digit(3); run_digit(4); run_digit(5);
    check("t5_history", history_digits, 16'h2345);
    check("t5_count", history_count, 4);
    press(); tick(2);
    done = 1; pd = 12; tick(1); done = 0;
    check("t4_error", error, 1);
    check("t4_digit", output_digit, 11);
    check("t4_history", history_digits, 16'h2345);
    tick(2); press(); tick(6);
    check("t4_recovered", output_digit, 10);
    press(); tick(25);
    check("t3_error", error, 1);
    check("t3_nn_wait_len", last_nnw, 16);
    pr = 0; press(); tick(45);
    check("clr_timeout_error", error, 1);
    pr = 1; press(); tick(8);
    check("clr_recovered", enable_graphics, 1);
    press(); tick(3);
    reset = 1; tick(1);
    check("midrst_rst_nn", reset_nn, 1);
    check("midrst_en_nn", enable_nn, 0);
    check("midrst_hist", history_digits, 0);
    check("midrst_count", history_count, 0);
    reset = 0; tick(8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
